dr_memreq_arb: RTL
==================

DR_MEMREQ_ARB -- requirements
Module: dr_memreq_arb

Interface
REQ-001 SHALL take parameter PF_DEPTH, default 4, meaning prefetch queue entries; legal values are 4, 8 and 16.
REQ-002 SHALL take parameter STARVE_MAX, default 8, meaning consecutive demand grants allowed while a prefetch waits; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have demand ports dmd_valid in 1, dmd_retry out 1, dmd_drid in DR_reqid_type, dmd_cmd in SC_cmd_type, dmd_paddr in SC_paddr_type.
REQ-006 SHALL have prefetch ports pf_valid in 1, pf_retry out 1, pf_nid in SC_nodeid_type, pf_paddr in SC_paddr_type.
REQ-007 SHALL have memory ports drtomem_req_valid out 1, drtomem_req_retry in 1, drtomem_req_drid out DR_reqid_type, drtomem_req_cmd out SC_cmd_type, drtomem_req_paddr out SC_paddr_type, drtomem_req_nid out SC_nodeid_type, drtomem_req_pf out 1.

Function
REQ-008 A transfer on any channel SHALL occur on a clk edge where valid=1 and retry=0; the source holds its payload while retry=1.
REQ-009 The output stage SHALL be one register, either EMPTY or FULL, and an accepted winner SHALL appear on drtomem_req_* the cycle after acceptance (latency 1).
REQ-010 The output stage SHALL load a new winner when it is EMPTY or is transferring this cycle (back-to-back, full throughput).
REQ-011 pf_retry SHALL be tied to 0; every prefetch is pushed into a PF_DEPTH FIFO.
REQ-012 A push to a full FIFO with no pop in the same cycle SHALL overwrite the oldest entry, advance the head, and leave the count at PF_DEPTH.
REQ-013 A push and a pop in the same cycle to a full FIFO SHALL drop nothing.
REQ-014 FIFO pointers SHALL be log2(PF_DEPTH) bits wide and wrap modulo PF_DEPTH; the count SHALL be log2(PF_DEPTH)+1 bits wide.
REQ-015 Arbitration SHALL run only when the output stage can load, and a demand request SHALL win by default.
REQ-016 The FIFO head SHALL win when dmd_valid=0, or when starve_cnt==STARVE_MAX and the FIFO is non-empty.
REQ-017 starve_cnt (8 bits) SHALL increment on each demand grant while the FIFO is non-empty, clear on each prefetch grant, and clear whenever the FIFO is empty.
REQ-018 dmd_retry SHALL be 1 when the output stage cannot load or the prefetch wins that cycle, and 0 otherwise.
REQ-019 A prefetch winner SHALL drive drid=DR_PF_DRID, cmd=DR_PF_CMD, its nid and paddr, and pf=1.
REQ-020 A demand winner SHALL drive its drid, cmd and paddr, nid=0 and pf=0.

Reset
REQ-021 While reset=0: drtomem_req_valid=0, all drtomem_req_* payload=0, dmd_retry=1, pf_retry=0, FIFO empty, pointers=0, starve_cnt=0, output stage EMPTY.
REQ-022 Reset asserted mid-operation SHALL discard any queued or staged request immediately, without waiting for a clock edge.
REQ-023 The first arbitration SHALL occur on the first clk edge after reset deasserts.

Configuration
REQ-024 With DR_MEMREQ_PF_DROP_STATS_EN defined, the block SHALL add output pf_drop_cnt (16 bits) that increments once per REQ-012 overwrite and saturates at 0xFFFF.
REQ-025 pf_drop_cnt SHALL reset to 0.
REQ-026 Without DR_MEMREQ_PF_DROP_STATS_EN the port and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-027 DR_PF_DRID (reserved DR_reqid_type value 0), DR_PF_CMD and the output payload struct SHALL live in the shared scmem package/header.
REQ-028 The prefetch queue SHALL be a sub-module dr_pf_dropq (parameter PF_DEPTH; push, pop, head, count, dropped pulse).
REQ-029 Arbitration, starve_cnt and the output stage SHALL stay in dr_memreq_arb.

Verification
REQ-030 The bench SHALL cover: dmd drid=5 paddr=0x1000 alone, retry=0 -> output valid next cycle with drid=5 paddr=0x1000 pf=0.
REQ-031 The bench SHALL cover: 6 pf pushes (paddr 0x100..0x600) with the output retried, PF_DEPTH=4 -> queue holds 0x300..0x600 and pf_drop_cnt=2 (macro on).
REQ-032 The bench SHALL cover: continuous dmd_valid plus one queued pf, STARVE_MAX=8 -> 8 demand grants, then the pf is granted (dmd_retry=1 that cycle), then demand resumes.
REQ-033 The bench SHALL cover: drtomem_req_retry=1 for 5 cycles with the output FULL -> payload stable, dmd_retry=1, and the request emitted once after retry drops.
REQ-034 The bench SHALL cover: full FIFO, simultaneous pf push and pf pop -> no drop, count stays 4.
REQ-035 The bench SHALL cover: reset pulsed low mid-stall with the FIFO at 3 entries -> valid=0 at once, count=0 and starve_cnt=0 after release.

Source files
------------

// File: rtl/scmem_pkg.sv
// Shared scmem types: request payload fields, reserved prefetch drid/cmd, memory request struct.
package scmem_pkg;

  typedef logic [5:0]  DR_reqid_type;
  typedef logic [3:0]  SC_cmd_type;
  typedef logic [31:0] SC_paddr_type;
  typedef logic [4:0]  SC_nodeid_type;

  // drid 0 is never issued by a demand source; it tags prefetches on the memory side.
  localparam DR_reqid_type DR_PF_DRID = 6'd0;
  localparam SC_cmd_type   DR_PF_CMD  = 4'h6;

  typedef struct packed {
    DR_reqid_type  drid;
    SC_cmd_type    cmd;
    SC_paddr_type  paddr;
    SC_nodeid_type nid;
    logic          pf;
  } DR_memreq_type;

  typedef struct packed {
    SC_nodeid_type nid;
    SC_paddr_type  paddr;
  } DR_pfreq_type;

  typedef enum logic {StEmpty, StFull} dr_ostage_e;

endpackage

// File: rtl/dr_pf_dropq.sv
// Prefetch queue that never back-pressures: a push into a full queue evicts the oldest entry.
module dr_pf_dropq
  import scmem_pkg::*;
#(
  parameter int unsigned PF_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  DR_pfreq_type              push_data,
  input  logic                      pop,
  output DR_pfreq_type              head,
  output logic [$clog2(PF_DEPTH):0] count,
  output logic                      dropped
);

  localparam int unsigned PtrW = $clog2(PF_DEPTH);

  DR_pfreq_type    mem_q [PF_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [PtrW:0]   count_q;
  logic            full, do_pop, overwrite;

  assign full      = (count_q == (PtrW + 1)'(PF_DEPTH));
  assign do_pop    = pop && (count_q != '0);
  // When full, tail aliases head, so the push lands on the oldest slot.
  assign overwrite = push && full && !do_pop;
  assign dropped   = overwrite;
  assign head      = mem_q[head_q];
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (do_pop || overwrite) head_q <= head_q + 1'b1;
      if (push && !do_pop && !full) count_q <= count_q + 1'b1;
      else if (do_pop && !push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/dr_memreq_arb.sv
// Demand/prefetch arbiter feeding a single-register memory request stage.
// Optional DR_MEMREQ_PF_DROP_STATS_EN adds a saturating pf_drop_cnt output.
module dr_memreq_arb
  import scmem_pkg::*;
#(
  parameter int unsigned PF_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dmd_valid,
  output logic          dmd_retry,
  input  DR_reqid_type  dmd_drid,
  input  SC_cmd_type    dmd_cmd,
  input  SC_paddr_type  dmd_paddr,
  input  logic          pf_valid,
  output logic          pf_retry,
  input  SC_nodeid_type pf_nid,
  input  SC_paddr_type  pf_paddr,
  output logic          drtomem_req_valid,
  input  logic          drtomem_req_retry,
  output DR_reqid_type  drtomem_req_drid,
  output SC_cmd_type    drtomem_req_cmd,
  output SC_paddr_type  drtomem_req_paddr,
  output SC_nodeid_type drtomem_req_nid,
  output logic          drtomem_req_pf
`ifdef DR_MEMREQ_PF_DROP_STATS_EN
  ,
  output logic [15:0]   pf_drop_cnt
`endif
);

  dr_ostage_e                state_q, state_d;
  DR_memreq_type             out_q, out_d;
  logic [7:0]                starve_cnt_q, starve_cnt_d;
  logic                      can_load, fifo_nonempty, pf_win, dmd_win, load;
  DR_pfreq_type              pf_head;
  logic [$clog2(PF_DEPTH):0] pf_count;
  logic                      pf_dropped;

  dr_pf_dropq #(
    .PF_DEPTH(PF_DEPTH)
  ) u_pfq (
    .clk      (clk),
    .reset    (reset),
    .push     (pf_valid),
    .push_data('{nid: pf_nid, paddr: pf_paddr}),
    .pop      (pf_win),
    .head     (pf_head),
    .count    (pf_count),
    .dropped  (pf_dropped)
  );

  always_comb begin
    can_load      = (state_q == StEmpty) || !drtomem_req_retry;
    fifo_nonempty = (pf_count != '0);
    pf_win        = can_load && fifo_nonempty &&
                    (!dmd_valid || (starve_cnt_q == 8'(STARVE_MAX)));
    dmd_win       = can_load && dmd_valid && !pf_win;
    load          = pf_win || dmd_win;
  end

  always_comb begin
    out_d        = out_q;
    starve_cnt_d = starve_cnt_q;
    if (pf_win) begin
      out_d = '{drid: DR_PF_DRID, cmd: DR_PF_CMD, paddr: pf_head.paddr, nid: pf_head.nid,
                pf: 1'b1};
    end else if (dmd_win) begin
      out_d = '{drid: dmd_drid, cmd: dmd_cmd, paddr: dmd_paddr, nid: '0, pf: 1'b0};
    end
    if (!fifo_nonempty || pf_win) starve_cnt_d = '0;
    else if (dmd_win)             starve_cnt_d = starve_cnt_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    if (load) state_d = StFull;
    else if ((state_q == StFull) && !drtomem_req_retry) state_d = StEmpty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      out_q        <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    drtomem_req_valid = (state_q == StFull);
    drtomem_req_drid  = out_q.drid;
    drtomem_req_cmd   = out_q.cmd;
    drtomem_req_paddr = out_q.paddr;
    drtomem_req_nid   = out_q.nid;
    drtomem_req_pf    = out_q.pf;
    // Reset gates retry directly since the output stage reads EMPTY while held in reset.
    dmd_retry         = !reset || !can_load || pf_win;
    pf_retry          = 1'b0;
  end

`ifdef DR_MEMREQ_PF_DROP_STATS_EN
  logic [15:0] pf_drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_drop_cnt_q <= '0;
    end else if (pf_dropped && (pf_drop_cnt_q != 16'hFFFF)) begin
      pf_drop_cnt_q <= pf_drop_cnt_q + 16'd1;
    end
  end

  assign pf_drop_cnt = pf_drop_cnt_q;
`else
  logic unused_pf_dropped;
  assign unused_pf_dropped = pf_dropped;
`endif

endmodule
